// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN sample type, layer-1 geometry and pooling FSM states
package cnn_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;

  localparam int CONV1_MAP_W   = 88;
  localparam int POOL1_MAP_W   = CONV1_MAP_W / 2;
  localparam int POOL1_OUT_NUM = POOL1_MAP_W * POOL1_MAP_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } pool_state_t;

endpackage

// File: rtl/pool_relu_2x2_if.sv
// rtl/pool_relu_2x2_if.sv - sample stream and frame control bundle for the 2x2 pooling stage
interface pool_relu_2x2_if #(
  parameter int DATA_W = cnn_pkg::DATA_W
);

  logic                     start;
  logic signed [DATA_W-1:0] map_in;
  logic                     valid_in;
  logic signed [DATA_W-1:0] map_out;
  logic                     valid_out;
  logic                     ready;

  modport master (
    output start, map_in, valid_in,
    input  map_out, valid_out, ready
  );

  modport slave (
    input  start, map_in, valid_in,
    output map_out, valid_out, ready
  );

endinterface

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - half-row buffer of horizontal maxima, sync write, async read
module pool_line_buf #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DEPTH  = cnn_pkg::POOL1_MAP_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // No reset: every entry is rewritten on an even row before the odd row reads it.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pool_relu_2x2.sv
// rtl/pool_relu_2x2.sv - 2x2 stride-2 max pooling with optional ReLU (POOL_RELU_EN)
module pool_relu_2x2 #(
  parameter int DATA_W  = cnn_pkg::DATA_W,
  parameter int MAP_W   = cnn_pkg::CONV1_MAP_W,
  parameter int OUT_NUM = cnn_pkg::POOL1_OUT_NUM
) (
  input  logic             clk_in,
  input  logic             rst_n,
  pool_relu_2x2_if.slave   bus
);

  import cnn_pkg::*;

  localparam int HALF_W = MAP_W / 2;
  localparam int CW     = $clog2(MAP_W);
  localparam int AW     = $clog2(HALF_W);
  localparam int OCW    = $clog2(OUT_NUM + 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(MAP_W - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_NUM);

  typedef logic signed [DATA_W-1:0] samp_t;

  function automatic samp_t smax(input samp_t a, input samp_t b);
    return (a > b) ? a : b;
  endfunction

  pool_state_t    state, state_next;
  logic [CW-1:0]  col, row;
  logic [OCW-1:0] out_cnt;
  samp_t          hold, hmax, vmax, line_rd, pool_val, map_r;
  logic           valid_r;
  logic           take, lb_we;
  logic [AW-1:0]  lb_addr;

  // Samples count only in RUN; a dropped start wins over a coincident valid.
  assign take    = bus.start && bus.valid_in && (state == RUN);
  assign lb_we   = take && col[0] && !row[0];
  assign lb_addr = AW'(col >> 1);

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (HALF_W),
    .ADDR_W (AW)
  ) u_line_buf (
    .clk_in (clk_in),
    .we     (lb_we),
    .addr   (lb_addr),
    .wdata  (hmax),
    .rdata  (line_rd)
  );

  always_comb begin
    hmax = smax(hold, bus.map_in);
    vmax = smax(line_rd, hmax);
`ifdef POOL_RELU_EN
    pool_val = vmax[DATA_W-1] ? '0 : vmax;
`else
    pool_val = vmax;
`endif
  end

  always_comb begin
    state_next = state;
    if (!bus.start) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     if (out_cnt == OUT_LAST) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      out_cnt <= '0;
      hold    <= '0;
      map_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_next;
      valid_r <= 1'b0;
      if (!bus.start) begin
        col     <= '0;
        row     <= '0;
        out_cnt <= '0;
        hold    <= '0;
      end else if (take) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == COL_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          hold <= bus.map_in;
        end else if (row[0]) begin
          map_r   <= pool_val;
          valid_r <= 1'b1;
          if (out_cnt != OUT_LAST) out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.map_out   = map_r;
  assign bus.valid_out = valid_r;
  assign bus.ready     = (state != DONE);

endmodule

// File: tb/tb_pool_relu_2x2.sv
// tb/tb_pool_relu_2x2.sv - scoreboard bench for pool_relu_2x2 on full 88x88 frames
module tb_pool_relu_2x2;

  import cnn_pkg::*;

  localparam int MW = 88;
  localparam int ON = 1936;

  typedef struct {
    sample_t d;
    int      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pool_relu_2x2_if #(.DATA_W(16)) bus ();

  pool_relu_2x2 #(
    .DATA_W  (16),
    .MAP_W   (MW),
    .OUT_NUM (ON)
  ) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  sample_t img [MW][MW];
  exp_t    sbq [$];
  exp_t    popped;
  int      n_cmp = 0;
  int      n_err = 0;
  int      cyc   = 0;
  int      n_vout = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic sample_t model_relu(input sample_t v);
`ifdef POOL_RELU_EN
    return (v < 0) ? sample_t'(0) : v;
`else
    return v;
`endif
  endfunction

  function automatic sample_t pool_exp(input int r, input int c);
    sample_t m;
    m = img[r-1][c-1];
    if (img[r-1][c] > m) m = img[r-1][c];
    if (img[r][c-1] > m) m = img[r][c-1];
    if (img[r][c] > m) m = img[r][c];
    return model_relu(m);
  endfunction

  // mode 0: signed ramp with corner quads, 1: random, 2: all -100
  task automatic fill(input int mode);
    for (int r = 0; r < MW; r++)
      for (int c = 0; c < MW; c++)
        case (mode)
          0:       img[r][c] = sample_t'(r * MW + c - 3000);
          1:       img[r][c] = sample_t'($urandom);
          default: img[r][c] = -16'sd100;
        endcase
    if (mode == 0) begin
      img[0][0] = -16'sd32768; img[0][1] = 16'sd32767; img[1][0] = -16'sd1; img[1][1] = 16'sd0;
      img[0][2] = -16'sd5;     img[0][3] = -16'sd3;    img[1][2] = -16'sd7; img[1][3] = -16'sd9;
    end
  endtask

  task automatic drive(input int n, input bit gapped, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      int r, c;
      r = (i / MW) % MW;
      c = i % MW;
      if (gapped && c == 0 && i != 0) begin
        bus.valid_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
      end
      bus.valid_in = 1'b1;
      bus.map_in   = img[r][c];
      if (expect_out && (r % 2 == 1) && (c % 2 == 1))
        sbq.push_back('{pool_exp(r, c), cyc + 1});
      @(posedge clk);
      #1;
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic begin_frame();
    n_vout    = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called right after a full frame was driven: final output is visible now.
  task automatic end_frame_check(input string tag);
    check_eq({tag, "_last_vout"}, 32'(bus.valid_out), 32'd1);
    check_eq({tag, "_ready_hi"}, 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    check_eq({tag, "_ready_lo"}, 32'(bus.ready), 32'd0);
    check_eq({tag, "_count"}, 32'(n_vout), 32'(ON));
    check_eq({tag, "_sbq_empty"}, 32'(sbq.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid_out) begin
      n_vout++;
      if (sbq.size() == 0) begin
        check_eq("spurious_vout", 32'(bus.valid_out), 32'd0);
      end else begin
        popped = sbq.pop_front();
        check_eq("map_out", 32'(bus.map_out), 32'(popped.d));
        check_eq("latency", 32'(cyc), 32'(popped.cyc));
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.valid_in = 1'b0;
    bus.map_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_map_out", 32'(bus.map_out), 32'd0);
    check_eq("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    rst_n = 1'b1;

    // Directed frame with mixed-sign quads, then valids while DONE
    fill(0);
    begin_frame();
    drive(MW * MW, 1'b0, 1'b1);
    end_frame_check("directed");
    drive(300, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("done_count", 32'(n_vout), 32'(ON));
    check_eq("done_ready", 32'(bus.ready), 32'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("restart_ready", 32'(bus.ready), 32'd1);

    // Gapped random frame: 88 valids per 96 cycles
    fill(1);
    begin_frame();
    drive(MW * MW, 1'b1, 1'b1);
    end_frame_check("gapped");
    bus.start = 1'b0;
    @(posedge clk);
    #1;

    // Partial frame abandoned by start, then a fresh frame
    fill(1);
    begin_frame();
    drive(100, 1'b0, 1'b1);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("partial_count", 32'(n_vout), 32'd6);
    repeat (2) @(posedge clk);
    #1;
    fill(1);
    begin_frame();
    drive(MW * MW, 1'b0, 1'b1);
    end_frame_check("after_stop");
    bus.start = 1'b0;
    @(posedge clk);
    #1;

    // Partial frame abandoned by reset, then an all-negative frame
    fill(1);
    begin_frame();
    drive(200, 1'b0, 1'b1);
    check_eq("prereset_count", 32'(n_vout), 32'd44);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_map_out", 32'(bus.map_out), 32'd0);
    check_eq("midrst_valid_out", 32'(bus.valid_out), 32'd0);
    check_eq("midrst_ready", 32'(bus.ready), 32'd1);
    rst_n = 1'b1;
    fill(2);
    begin_frame();
    drive(MW * MW, 1'b0, 1'b1);
    end_frame_check("after_rst");
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pool_relu_2x2.md
# pool_relu_2x2

Streaming 2×2 stride-2 max-pooling stage with optional ReLU. It sits directly downstream of the layer-1 9×9 convolution and consumes that stage's 88×88 row-major `map_out`/`save` stream. It emits a 44×44 pooled map with a `valid_out` strobe to the next convolution stage, and uses a half-width line buffer so that no full frame is stored.

## Interface
Parameters:
- `DATA_W`, 16: sample width, signed two's-complement Q3.12.
- `MAP_W`, 88: input map width and height. Must be even.
- `OUT_NUM`, 1936: pooled outputs per frame, equal to (MAP_W/2)².

Ports:
- `clk_in`, input, 1: clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: frame enable, held high for the whole frame. Low forces the block idle and clears its counters.
- `map_in`, input, DATA_W: conv output sample, signed.
- `valid_in`, input, 1: `map_in` qualifier; connects to the conv `save`. Gaps between valids are arbitrary.
- `map_out`, output, DATA_W: pooled sample.
- `valid_out`, output, 1: one-cycle strobe per pooled sample.
- `ready`, output, 1: high while a frame is incomplete; low once OUT_NUM outputs have been emitted.

## Operation
- FSM states:
  - IDLE: entered on reset or whenever `start`=0.
  - IDLE→RUN when `start`=1.
  - RUN→DONE on the cycle `out_cnt` reaches OUT_NUM.
  - RUN or DONE→IDLE when `start`=0. `start`=0 takes priority over a coincident `valid_in`.
- Counters `col` (0..MAP_W-1) and `row` (0..MAP_W-1) advance only on `valid_in` in RUN.
  - `col` wraps to 0 after MAP_W-1, and `row` increments at that point.
  - `row` wraps after MAP_W-1 (end of frame).
- Even `col`: latch `map_in` into `hold`.
- Odd `col`: `hmax` = signed max(`hold`, `map_in`).
  - Even `row`: write `hmax` to `line_buf[col>>1]`.
  - Odd `row`: `vmax` = signed max(`line_buf[col>>1]`, `hmax`), then register it to `map_out` and pulse `valid_out`.
- Comparisons are signed at full DATA_W. No arithmetic is performed, so overflow cannot occur. On equal values, either operand may be selected, since the result is the same.
- `out_cnt` increments on each `valid_out` and saturates at OUT_NUM.
- In DONE, `valid_in` is ignored and `valid_out` stays 0.
- `line_buf` contents are not cleared on reset. Every entry is written on an even row before it is read on an odd row.

## Timing
- Reset values: `map_out`=0, `valid_out`=0, `ready`=1, state IDLE, `col`=`row`=`out_cnt`=0, `hold`=0.
- Latency: `valid_out`/`map_out` assert exactly 1 cycle after the `valid_in` cycle carrying the odd-row, odd-col sample.
- Back-to-back `valid_in` is sustained, giving at most one output per two input valids.
- Output rate is bursty: one output per 2 inputs on odd rows, none on even rows.
- `ready` falls 1 cycle after the final `valid_out`. It returns to 1 the cycle after `start` falls.
- A reset asserted mid-frame restores all reset values on the next edge. Any partial row is discarded.

## Configuration
- `POOL_RELU_EN` defined: `map_out` = (`vmax` < 0) ? 0 : `vmax`. ReLU is applied before pooling's output register; pooling and ReLU commute.
- `POOL_RELU_EN` undefined: `map_out` = `vmax`, so negative values pass through.
- Latency is identical in both configurations.

## Structure
- Shared package `cnn_pkg` holds:
  - `DATA_W`.
  - The `sample_t` signed typedef.
  - The layer-1 geometry constants: conv output 88, pooled 44, OUT_NUM 1936.
  - The FSM state typedef `pool_state_t` (IDLE/RUN/DONE).
- Sub-module `pool_line_buf`:
  - MAP_W/2 × DATA_W storage.
  - One synchronous write port and one asynchronous read port, with an address width of clog2(MAP_W/2).
  - Maps to distributed RAM.

## Test plan
- 4×4 frame (MAP_W=4, OUT_NUM=4), inputs 0..15 row-major, ReLU on → outputs 5, 7, 13, 15. `ready` falls 1 cycle after the 4th `valid_out`.
- MAP_W=4, all samples −100 (0xFF9C):
  - ReLU on → four outputs of 0.
  - ReLU off → four outputs of 0xFF9C.
- Mixed signs: quad {−32768, 32767, −1, 0} → output 32767. Quad {−5, −3, −7, −9} → −3 with ReLU off, 0 with ReLU on.
- Gapped `valid_in` (88 valid of every 96 cycles), full 88×88 frame against a golden model → exactly 1936 `valid_out`s, all matching, with `ready` then 0.
- `start` dropped after 100 inputs, then re-raised with a fresh frame → no output is corrupted by the earlier partial data and `out_cnt` restarts at 0. The same check applies when `rst_n` is pulsed low mid-frame.
- `valid_in` continuing in DONE → no further `valid_out` and `out_cnt` stays 1936.
